alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 8-bit ALU of the pipelined processor. It accepts operation requests (opcode plus two operands) from two clients, such as the execute stage and a branch/address unit. It grants one client at a time, drives the ALU's control and operand inputs from registers, and captures the combinational ALU result. It then returns the result to the granted client with a one-cycle done pulse.

---
 rtl/alu_arbiter_if.sv | 30 +++
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/operand bus between the two ALU clients, the shared ALU, and the arbiter.
// The arbiter takes the slave side. The clients and the ALU take the master side.
interface alu_arbiter_if;
  logic [1:0] req;
  logic [1:0] op0;
  logic [1:0] op1;
  logic [7:0] a0;
  logic [7:0] b0;
  logic [7:0] a1;
  logic [7:0] b1;
  logic [1:0] alu_con;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [7:0] result;
  logic       busy;
  logic [7:0] op_count;

  modport slave (
    input  req, op0, op1, a0, b0, a1, b1, alu_result,
    output alu_con, alu_a, alu_b, gnt, done, result, busy, op_count
  );

  modport master (
    output req, op0, op1, a0, b0, a1, b1, alu_result,
    input  alu_con, alu_a, alu_b, gnt, done, result, busy, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter for two clients sharing one 8-bit ALU.
// Each grant runs IDLE -> EXEC -> DONE and returns the result with a one-cycle done pulse.
module alu_arbiter (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic [7:0] result_q, result_d;
  logic [1:0] con_q, con_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      con_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      con_q    <= con_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    result_d = result_q;
    con_d    = con_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    // On a tie the client not served last wins; otherwise the sole requester wins.
    win      = (bus.req == 2'b11) ? ~last_q : bus.req[1];

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          con_d   = win ? bus.op1 : bus.op0;
          a_d     = win ? bus.a1  : bus.a0;
          b_d     = win ? bus.b1  : bus.b0;
          gnt_d   = win ? 2'b10   : 2'b01;
          last_d  = win;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.alu_result;
        done_d   = gnt_q;
        cnt_d    = cnt_q + 8'd1;
        state_d  = DONE;
      end
      DONE: begin
        done_d  = '0;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        done_d  = '0;
      end
    endcase
  end

  assign bus.alu_con  = con_q;
  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.op_count = cnt_q;
  assign bus.busy     = (state_q == EXEC) || (state_q == DONE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. The ALU and the expected transaction outcomes come
// from a transaction-level model: opcode arithmetic, the tie-break rule and an operation count.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   exp_count = 0;
  bit   exp_last = 1'b1;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    case (op)
      2'd0:    return 8'((int'(a) + int'(b)) % 256);
      2'd1:    return 8'((int'(a) - int'(b) + 256) % 256);
      2'd2:    return (sa < sb) ? 8'h01 : 8'h00;
      default: return 8'((int'(b) * 16) % 256);
    endcase
  endfunction

  // Behavioural ALU attached to the arbiter's registered control/operand outputs.
  assign bus.alu_result = alu_ref(bus.alu_con, bus.alu_a, bus.alu_b);

  task automatic idle_inputs();
    bus.req = 2'b00;
    bus.op0 = 2'b00; bus.a0 = 8'h00; bus.b0 = 8'h00;
    bus.op1 = 2'b00; bus.a1 = 8'h00; bus.b1 = 8'h00;
  endtask

  task automatic rand_operands();
    bus.op0 = 2'($urandom_range(0, 3)); bus.a0 = 8'($urandom); bus.b0 = 8'($urandom);
    bus.op1 = 2'($urandom_range(0, 3)); bus.a1 = 8'($urandom); bus.b1 = 8'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_count = 0;
    exp_last  = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt); end
    vectors++; if (bus.done !== 2'b00) begin miscompares++; $display("FAIL reset_done: got %b expected 00", bus.done); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.result !== 8'h00) begin miscompares++; $display("FAIL reset_result: got %h expected 00", bus.result); end
    vectors++; if (bus.op_count !== 8'h00) begin miscompares++; $display("FAIL reset_count: got %h expected 00", bus.op_count); end
    vectors++; if ({bus.alu_con, bus.alu_a, bus.alu_b} !== 18'h0) begin miscompares++; $display("FAIL reset_alu_regs: got %h/%h/%h expected 0/00/00", bus.alu_con, bus.alu_a, bus.alu_b); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_count = 0;
    exp_last  = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_single_add();
    bus.req = 2'b01; bus.op0 = 2'b00; bus.a0 = 8'h7F; bus.b0 = 8'h02;
    @(posedge clk); #1;
    vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL add_gnt: got %b expected 01", bus.gnt); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL add_busy_exec: got %b expected 1", bus.busy); end
    vectors++; if ({bus.alu_con, bus.alu_a, bus.alu_b} !== {2'b00, 8'h7F, 8'h02}) begin miscompares++; $display("FAIL add_alu_regs: got %h/%h/%h expected 0/7f/02", bus.alu_con, bus.alu_a, bus.alu_b); end
    vectors++; if (bus.done !== 2'b00) begin miscompares++; $display("FAIL add_done_early: got %b expected 00", bus.done); end
    @(posedge clk); #1;
    exp_count++;
    exp_last = 1'b0;
    vectors++; if (bus.done !== 2'b01) begin miscompares++; $display("FAIL add_done: got %b expected 01", bus.done); end
    vectors++; if (bus.result !== 8'h81) begin miscompares++; $display("FAIL add_result: got %h expected 81", bus.result); end
    vectors++; if (bus.op_count !== 8'(exp_count)) begin miscompares++; $display("FAIL add_count: got %h expected %h", bus.op_count, 8'(exp_count)); end
    bus.req = 2'b00;
    @(posedge clk); #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL add_busy_end: got %b expected 0", bus.busy); end
    vectors++; if ({bus.gnt, bus.done} !== 4'b0000) begin miscompares++; $display("FAIL add_clear: got gnt=%b done=%b expected 00/00", bus.gnt, bus.done); end
    vectors++; if (bus.result !== 8'h81) begin miscompares++; $display("FAIL add_result_hold: got %h expected 81", bus.result); end
  endtask

  task automatic test_ops();
    logic [1:0] d_op [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
    logic [7:0] d_a  [4] = '{8'h05, 8'hFE, 8'h01, 8'h00};
    logic [7:0] d_b  [4] = '{8'h07, 8'h01, 8'hFE, 8'h3C};
    logic [7:0] d_r  [4] = '{8'hFE, 8'h01, 8'h00, 8'hC0};
    for (int unsigned i = 0; i < 28; i++) begin
      bit         c;
      logic [7:0] expv;
      rand_operands();
      if (i < 4) begin
        c = 1'b1;
        bus.op1 = d_op[i]; bus.a1 = d_a[i]; bus.b1 = d_b[i];
        expv = d_r[i];
      end else begin
        c = 1'($urandom_range(0, 1));
        expv = c ? alu_ref(bus.op1, bus.a1, bus.b1) : alu_ref(bus.op0, bus.a0, bus.b0);
      end
      bus.req = c ? 2'b10 : 2'b01;
      @(posedge clk); #1;
      vectors++; if (bus.gnt !== bus.req) begin miscompares++; $display("FAIL ops_gnt[%0d]: got %b expected %b", i, bus.gnt, bus.req); end
      @(posedge clk); #1;
      exp_count++;
      exp_last = c;
      vectors++; if (bus.done !== bus.req) begin miscompares++; $display("FAIL ops_done[%0d]: got %b expected %b", i, bus.done, bus.req); end
      vectors++; if (bus.result !== expv) begin miscompares++; $display("FAIL ops_result[%0d]: got %h expected %h", i, bus.result, expv); end
      vectors++; if (bus.op_count !== 8'(exp_count)) begin miscompares++; $display("FAIL ops_count[%0d]: got %h expected %h", i, bus.op_count, 8'(exp_count)); end
      bus.req = 2'b00;
      @(posedge clk); #1;
      vectors++; if (bus.done !== 2'b00) begin miscompares++; $display("FAIL ops_done_pulse[%0d]: got %b expected 00", i, bus.done); end
    end
  endtask

  task automatic test_round_robin();
    int prev_done = -1;
    idle_inputs();
    do_reset();
    rand_operands();
    bus.req = 2'b11;
    for (int unsigned k = 0; k < 4; k++) begin
      bit         w;
      bit         got;
      logic [7:0] expv;
      w    = ~exp_last;
      expv = w ? alu_ref(bus.op1, bus.a1, bus.b1) : alu_ref(bus.op0, bus.a0, bus.b0);
      got  = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (bus.done !== 2'b00) begin got = 1'b1; break; end
      end
      vectors++;
      if (!got) begin
        miscompares++; $display("FAIL rr_timeout[%0d]: got no done expected done within 6 cycles", k);
      end else begin
        exp_count++;
        vectors++; if (bus.done !== (w ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_winner[%0d]: got %b expected %b", k, bus.done, w ? 2'b10 : 2'b01); end
        vectors++; if (bus.result !== expv) begin miscompares++; $display("FAIL rr_result[%0d]: got %h expected %h", k, bus.result, expv); end
        vectors++; if (bus.op_count !== 8'(exp_count)) begin miscompares++; $display("FAIL rr_count[%0d]: got %h expected %h", k, bus.op_count, 8'(exp_count)); end
        if (prev_done >= 0) begin
          vectors++; if (cyc - prev_done != 3) begin miscompares++; $display("FAIL rr_spacing[%0d]: got %0d expected 3", k, cyc - prev_done); end
        end
        prev_done = cyc;
      end
      exp_last = w;
    end
    bus.req = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_stability();
    bus.req = 2'b01; bus.op0 = 2'b00; bus.a0 = 8'h10; bus.b0 = 8'h20;
    @(posedge clk); #1;
    bus.a0 = 8'hFF; bus.b0 = 8'h00; bus.op0 = 2'b01;
    @(posedge clk); #1;
    exp_count++;
    vectors++; if (bus.result !== 8'h30) begin miscompares++; $display("FAIL stab_result: got %h expected 30", bus.result); end
    bus.req = 2'b10; bus.op1 = 2'b00; bus.a1 = 8'h03; bus.b1 = 8'h04;
    #1;
    vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL stab_gnt_done_state: got %b expected 01", bus.gnt); end
    @(posedge clk); #1;
    vectors++; if ({bus.gnt, bus.done, bus.busy} !== 5'b0) begin miscompares++; $display("FAIL stab_idle: got gnt=%b done=%b busy=%b expected 00/00/0", bus.gnt, bus.done, bus.busy); end
    @(posedge clk); #1;
    vectors++; if (bus.gnt !== 2'b10) begin miscompares++; $display("FAIL stab_new_gnt: got %b expected 10", bus.gnt); end
    @(posedge clk); #1;
    exp_count++;
    exp_last = 1'b1;
    vectors++; if (bus.result !== 8'h07) begin miscompares++; $display("FAIL stab_new_result: got %h expected 07", bus.result); end
    vectors++; if (bus.op_count !== 8'(exp_count)) begin miscompares++; $display("FAIL stab_count: got %h expected %h", bus.op_count, 8'(exp_count)); end
    bus.req = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    idle_inputs();
    do_reset();
    bus.req = 2'b01; bus.op0 = 2'b00; bus.a0 = 8'h01; bus.b0 = 8'h01;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    vectors++; if ({bus.gnt, bus.done, bus.busy} !== 5'b0) begin miscompares++; $display("FAIL rst_mid_ctrl: got gnt=%b done=%b busy=%b expected 00/00/0", bus.gnt, bus.done, bus.busy); end
    vectors++; if (bus.result !== 8'h00) begin miscompares++; $display("FAIL rst_mid_result: got %h expected 00", bus.result); end
    vectors++; if (bus.op_count !== 8'h00) begin miscompares++; $display("FAIL rst_mid_count: got %h expected 00", bus.op_count); end
    vectors++; if (bus.alu_a !== 8'h00) begin miscompares++; $display("FAIL rst_mid_alu_a: got %h expected 00", bus.alu_a); end
    repeat (2) begin
      @(posedge clk); #1;
      vectors++; if (bus.done !== 2'b00) begin miscompares++; $display("FAIL rst_mid_no_done: got %b expected 00", bus.done); end
    end
    reset = 1'b0;
    exp_count = 0;
    exp_last  = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL rst_after_gnt: got %b expected 01", bus.gnt); end
    @(posedge clk); #1;
    exp_count++;
    exp_last = 1'b0;
    vectors++; if ({bus.done, bus.result} !== {2'b01, 8'h02}) begin miscompares++; $display("FAIL rst_after_done: got %b/%h expected 01/02", bus.done, bus.result); end
    vectors++; if (bus.op_count !== 8'(exp_count)) begin miscompares++; $display("FAIL rst_after_count: got %h expected %h", bus.op_count, 8'(exp_count)); end
    bus.req = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    idle_inputs();
    do_reset();
    for (int unsigned i = 0; i < 256; i++) begin
      bit         c;
      bit         got;
      logic [7:0] expv;
      rand_operands();
      c = 1'($urandom_range(0, 1));
      expv = c ? alu_ref(bus.op1, bus.a1, bus.b1) : alu_ref(bus.op0, bus.a0, bus.b0);
      bus.req = c ? 2'b10 : 2'b01;
      got = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (bus.gnt === 2'b11 || bus.done === 2'b11) begin
          vectors++; miscompares++; $display("FAIL wrap_onehot[%0d]: got gnt=%b done=%b expected at most one bit each", i, bus.gnt, bus.done);
        end
        if (bus.done !== 2'b00) begin got = 1'b1; break; end
      end
      vectors++;
      if (!got) begin
        miscompares++; $display("FAIL wrap_timeout[%0d]: got no done expected done within 4 cycles", i);
      end else begin
        exp_count++;
        vectors++; if (bus.result !== expv) begin miscompares++; $display("FAIL wrap_result[%0d]: got %h expected %h", i, bus.result, expv); end
        vectors++; if (bus.op_count !== 8'(exp_count)) begin miscompares++; $display("FAIL wrap_count[%0d]: got %h expected %h", i, bus.op_count, 8'(exp_count)); end
      end
      bus.req = 2'b00;
      @(posedge clk); #1;
    end
    vectors++; if (bus.op_count !== 8'h00) begin miscompares++; $display("FAIL wrap_final: got %h expected 00", bus.op_count); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_ops();
    test_round_robin();
    test_stability();
    test_reset_midop();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
